// File: rtl/way_age_victim_ctrl.sv
// way_age_victim_ctrl: per-set/per-way saturating age counters with a handshaked oldest-candidate victim picker
module way_age_victim_ctrl #(
  parameter int NUM_WAY       = 16,
  parameter int NUM_SET       = 4,
  parameter int SET_PTR_WIDTH = $clog2(NUM_SET),
  parameter int WAY_PTR_WIDTH = $clog2(NUM_WAY) + 1,
  parameter int AGE_WIDTH     = 4
) (
  input  logic                     clk_in,
  input  logic                     reset_n_in,
  input  logic                     access_valid_in,
  input  logic [SET_PTR_WIDTH-1:0] access_set_in,
  input  logic [WAY_PTR_WIDTH-1:0] access_way_in,
  input  logic                     victim_req_valid_in,
  output logic                     victim_req_ready_out,
  input  logic [SET_PTR_WIDTH-1:0] victim_req_set_in,
  input  logic [NUM_WAY-1:0]       victim_req_mask_in,
  output logic                     victim_resp_valid_out,
  input  logic                     victim_resp_ready_in,
  output logic [WAY_PTR_WIDTH-1:0] victim_resp_way_out,
  output logic [AGE_WIDTH-1:0]     victim_resp_age_out,
  output logic                     victim_resp_none_out
);
  typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;
  localparam logic [WAY_PTR_WIDTH-1:0] WAY_LIM = WAY_PTR_WIDTH'(NUM_WAY);
  state_t state_q, state_d;
  logic [AGE_WIDTH-1:0] age_q [NUM_SET][NUM_WAY];
  logic [AGE_WIDTH-1:0] age_d [NUM_SET][NUM_WAY];
  logic [AGE_WIDTH-1:0] snap_q [NUM_WAY];
  logic [AGE_WIDTH-1:0] snap_d [NUM_WAY];
  logic [NUM_WAY-1:0] mask_q, mask_d;
  logic [WAY_PTR_WIDTH-1:0] way_q, way_d;
  logic [AGE_WIDTH-1:0] age_out_q, age_out_d;
  logic none_q, none_d;
  logic acc_hit;
  assign acc_hit = access_valid_in && (access_way_in < WAY_LIM);
  assign victim_req_ready_out  = (state_q == IDLE);
  assign victim_resp_valid_out = (state_q == RESP);
  assign victim_resp_way_out   = way_q;
  assign victim_resp_age_out   = age_out_q;
  assign victim_resp_none_out  = none_q;
  always_comb begin
    age_d = age_q;
    for (int s = 0; s < NUM_SET; s++)
      for (int w = 0; w < NUM_WAY; w++)
        if (acc_hit && access_set_in == SET_PTR_WIDTH'(s))
          age_d[s][w] = (access_way_in == WAY_PTR_WIDTH'(w)) ? '0 :
                        (&age_q[s][w]) ? age_q[s][w] : age_q[s][w] + AGE_WIDTH'(1);
  end
  // Pairwise max reduction over the snapshot; on equal ages the lower-index side is kept.
  always_comb begin
    logic                     tv [NUM_WAY];
    logic [AGE_WIDTH-1:0]     ta [NUM_WAY];
    logic [WAY_PTR_WIDTH-1:0] ti [NUM_WAY];
    for (int i = 0; i < NUM_WAY; i++) begin
      tv[i] = mask_q[i];
      ta[i] = snap_q[i];
      ti[i] = WAY_PTR_WIDTH'(i);
    end
    for (int s = 1; s < NUM_WAY; s = s * 2)
      for (int i = 0; i < NUM_WAY; i = i + 2 * s)
        if (i + s < NUM_WAY && tv[i+s] && (!tv[i] || ta[i+s] > ta[i])) begin
          tv[i] = 1'b1;
          ta[i] = ta[i+s];
          ti[i] = ti[i+s];
        end
    state_d   = state_q;
    mask_d    = mask_q;
    snap_d    = snap_q;
    way_d     = way_q;
    age_out_d = age_out_q;
    none_d    = none_q;
    case (state_q)
      IDLE: if (victim_req_valid_in) begin
        state_d = CALC;
        mask_d  = victim_req_mask_in;
        snap_d  = age_q[victim_req_set_in];
      end
      CALC: begin
        state_d   = RESP;
        way_d     = tv[0] ? ti[0] : '0;
        age_out_d = tv[0] ? ta[0] : '0;
        none_d    = !tv[0];
      end
      RESP:    state_d = victim_resp_ready_in ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_in) begin
    if (!reset_n_in) begin
      state_q   <= IDLE;
      mask_q    <= '0;
      way_q     <= '0;
      age_out_q <= '0;
      none_q    <= 1'b0;
      for (int s = 0; s < NUM_SET; s++)
        for (int w = 0; w < NUM_WAY; w++)
          age_q[s][w] <= '0;
      for (int w = 0; w < NUM_WAY; w++)
        snap_q[w] <= '0;
    end else begin
      state_q   <= state_d;
      mask_q    <= mask_d;
      way_q     <= way_d;
      age_out_q <= age_out_d;
      none_q    <= none_d;
      age_q     <= age_d;
      snap_q    <= snap_d;
    end
  end
endmodule

// File: tb/tb_way_age_victim_ctrl.sv
// tb_way_age_victim_ctrl: directed and randomized checks of way_age_victim_ctrl against an age-table model
module tb_way_age_victim_ctrl;
  localparam int NW = 16;
  localparam int NS = 4;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic access_valid = 1'b0;
  logic [1:0] access_set = '0;
  logic [4:0] access_way = '0;
  logic req_valid = 1'b0;
  logic req_ready;
  logic [1:0] req_set = '0;
  logic [15:0] req_mask = '0;
  logic resp_valid;
  logic resp_ready = 1'b0;
  logic [4:0] resp_way;
  logic [3:0] resp_age;
  logic resp_none;
  int checks = 0;
  int fails = 0;
  bit rnd = 1'b0;
  int unsigned mage [NS][NW];

  way_age_victim_ctrl dut (
    .clk_in(clk), .reset_n_in(reset_n),
    .access_valid_in(access_valid), .access_set_in(access_set), .access_way_in(access_way),
    .victim_req_valid_in(req_valid), .victim_req_ready_out(req_ready),
    .victim_req_set_in(req_set), .victim_req_mask_in(req_mask),
    .victim_resp_valid_out(resp_valid), .victim_resp_ready_in(resp_ready),
    .victim_resp_way_out(resp_way), .victim_resp_age_out(resp_age),
    .victim_resp_none_out(resp_none)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Model: an access zeroes its way and ages every other way of the set, saturating at 15.
  task automatic step();
    if (rnd) begin
      access_valid = 1'($urandom_range(0, 1));
      access_set   = 2'($urandom_range(0, NS - 1));
      access_way   = 5'($urandom_range(0, NW + 1));
    end
    @(posedge clk);
    if (!reset_n) begin
      foreach (mage[s, w]) mage[s][w] = 0;
    end else if (access_valid && access_way < NW) begin
      for (int w = 0; w < NW; w++)
        mage[access_set][w] = (w == int'(access_way)) ? 0 : ((mage[access_set][w] < 15) ? mage[access_set][w] + 1 : 15);
    end
    #1;
  endtask

  task automatic pick(input int s, input logic [15:0] m, output int way, output int age, output int none);
    way = 0; age = 0; none = 1;
    for (int w = 0; w < NW; w++)
      if (m[w] && (none == 1 || int'(mage[s][w]) > age)) begin
        way = w; age = int'(mage[s][w]); none = 0;
      end
  endtask

  task automatic req_check(input logic [1:0] s, input logic [15:0] m, input int hold,
                           input int ew, input int ea, input int en);
    chk("ready_idle", 32'(req_ready), 1);
    req_valid = 1'b1; req_set = s; req_mask = m;
    step();
    req_valid = 1'b0; req_mask = '0;
    if (!rnd) access_valid = 1'b0;
    chk("calc_valid", 32'(resp_valid), 0);
    chk("calc_ready", 32'(req_ready), 0);
    step();
    chk("resp_valid", 32'(resp_valid), 1);
    chk("resp_way", 32'(resp_way), 32'(ew));
    chk("resp_age", 32'(resp_age), 32'(ea));
    chk("resp_none", 32'(resp_none), 32'(en));
    for (int i = 0; i < hold; i++) begin
      step();
      chk("hold_valid", 32'(resp_valid), 1);
      chk("hold_ready", 32'(req_ready), 0);
      chk("hold_way", 32'(resp_way), 32'(ew));
      chk("hold_age", 32'(resp_age), 32'(ea));
      chk("hold_none", 32'(resp_none), 32'(en));
    end
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    chk("post_valid", 32'(resp_valid), 0);
    chk("post_ready", 32'(req_ready), 1);
  endtask

  task automatic acc(input logic [1:0] s, input logic [4:0] w);
    access_valid = 1'b1; access_set = s; access_way = w;
    step();
    access_valid = 1'b0;
  endtask

  initial begin
    int ew, ea, en;
    reset_n = 1'b0;
    step(); step();
    reset_n = 1'b1;
    chk("rst_ready", 32'(req_ready), 1);
    chk("rst_valid", 32'(resp_valid), 0);
    chk("rst_way", 32'(resp_way), 0);
    chk("rst_age", 32'(resp_age), 0);
    chk("rst_none", 32'(resp_none), 0);
    req_check(2'd1, 16'hFFFF, 0, 0, 0, 0);
    acc(2'd2, 5'd3); acc(2'd2, 5'd5); acc(2'd2, 5'd3);
    req_check(2'd2, 16'hFFFF, 0, 0, 3, 0);
    req_check(2'd2, 16'h0020, 0, 5, 1, 0);
    req_check(2'd2, 16'h0008, 0, 3, 0, 0);
    for (int i = 0; i < 20; i++) acc(2'd0, 5'd7);
    req_check(2'd0, 16'h0080, 0, 7, 0, 0);
    req_check(2'd0, 16'hFF7F, 0, 0, 15, 0);
    req_check(2'd0, 16'h8080, 0, 15, 15, 0);
    acc(2'd0, 5'd20);
    req_check(2'd0, 16'h8000, 0, 15, 15, 0);
    req_check(2'd3, 16'h0000, 5, 0, 0, 1);
    acc(2'd1, 5'd0);
    access_valid = 1'b1; access_set = 2'd1; access_way = 5'd9;
    req_check(2'd1, 16'hFFFF, 0, 1, 1, 0);
    req_check(2'd1, 16'h0200, 0, 9, 0, 0);
    req_check(2'd1, 16'h0201, 0, 0, 1, 0);
    req_valid = 1'b1; req_set = 2'd2; req_mask = 16'hFFFF;
    step();
    req_valid = 1'b0;
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    chk("abort_valid", 32'(resp_valid), 0);
    chk("abort_ready", 32'(req_ready), 1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("abort_quiet", 32'(resp_valid), 0);
    end
    for (int s = 0; s < NS; s++) req_check(2'(s), 16'hFFFF, 0, 0, 0, 0);
    req_check(2'd2, 16'h0410, 0, 4, 0, 0);
    rnd = 1'b1;
    for (int n = 0; n < 60; n++) begin
      logic [1:0] s;
      logic [15:0] m;
      int sel;
      for (int i = 0; i < int'($urandom_range(0, 6)); i++) step();
      s = 2'($urandom_range(0, NS - 1));
      sel = int'($urandom_range(0, 5));
      m = (sel == 0) ? 16'h0000 : (sel == 1) ? 16'hFFFF : 16'($urandom);
      req_valid = 1'b1; req_set = s; req_mask = m;
      access_valid = 1'b1; access_set = 2'($urandom_range(0, NS - 1)); access_way = 5'($urandom_range(0, NW + 1));
      pick(int'(s), m, ew, ea, en);
      rnd = 1'b0;
      req_check(s, m, int'($urandom_range(0, 3)), ew, ea, en);
      rnd = 1'b1;
    end
    rnd = 1'b0;
    access_valid = 1'b0;
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
